signal_prescaler: RTL

- Front-end conditioning stage directly upstream of frequency_counter on the measured-signal path.
- Synchronises the asynchronous measure_signal_i into clk_i, applies a programmable glitch filter, detects qualified edges and divides them by a programmable ratio.
- Emits a divided square wave and an edge-pulse stream for the counter. Exposes a small Wishbone slave register window on the shared bus, with OR-combined dat_o/err_o/rty_o.

---
 rtl/signal_prescaler_pkg.sv | 36 +++
 rtl/signal_prescaler_glitch_filter.sv | 55 +++++
 rtl/signal_prescaler.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/signal_prescaler_pkg.sv
// Shared register map and field positions for the measured-signal front end
// and the frequency counter bus window.
package signal_prescaler_pkg;

  localparam logic [31:0] SP_BASE_ADDR = 32'h0000_0200;

  localparam logic [3:0] OFF_CTRL    = 4'h0;
  localparam logic [3:0] OFF_DIV     = 4'h4;
  localparam logic [3:0] OFF_EDGECNT = 4'h8;
  localparam logic [3:0] OFF_RSVD    = 4'hC;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_BIT = 1;
  localparam int CTRL_FILT_LSB = 8;
  localparam int CTRL_FILT_MSB = 15;

  typedef enum logic [1:0] {
    REG_CTRL    = 2'd0,
    REG_DIV     = 2'd1,
    REG_EDGECNT = 2'd2,
    REG_RSVD    = 2'd3
  } reg_sel_e;

  // Word decode; byte-lane bits are ignored.
  function automatic reg_sel_e decode_reg(input logic [3:0] off);
    reg_sel_e r;
    case ({off[3:2], 2'b00})
      OFF_CTRL:    r = REG_CTRL;
      OFF_DIV:     r = REG_DIV;
      OFF_EDGECNT: r = REG_EDGECNT;
      default:     r = REG_RSVD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/signal_prescaler_glitch_filter.sv
// Synchroniser followed by a run-length glitch filter; the filtered level only
// follows the synchronised input once it has disagreed for filt_len cycles.
module glitch_filter
  import signal_prescaler_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sig_i,
  input  logic [7:0] filt_len_i,
  input  logic       clr_run_i,
  output logic       filt_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_s;
  logic                   filt_q, filt_d;
  logic [7:0]             run_q, run_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sig_i};
    sync_s = sync_q[SYNC_STAGES-1];
    filt_d = filt_q;
    run_d  = run_q;
    if (filt_len_i == 8'd0) begin
      filt_d = sync_s;
      run_d  = 8'd0;
    end else if (sync_s == filt_q) begin
      run_d = 8'd0;
    end else if (8'(run_q + 8'd1) == filt_len_i) begin
      filt_d = sync_s;
      run_d  = 8'd0;
    end else begin
      run_d = run_q + 8'd1;
    end
    // Reprogramming restarts qualification so an old partial run cannot leak through.
    if (clr_run_i) run_d = 8'd0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      filt_q <= 1'b0;
      run_q  <= 8'd0;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      run_q  <= run_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/signal_prescaler.sv
// Measured-signal conditioning: filtered edge detect, divide-by-N prescaler and
// a 16-byte Wishbone register window (CTRL, DIV, EDGECNT).
module signal_prescaler
  import signal_prescaler_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = SP_BASE_ADDR,
  parameter int          SYNC_STAGES = 2,
  parameter int          DIV_WIDTH   = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  output logic        ack_o,
  output logic        err_o,
  output logic        rty_o,
  input  logic        signal_i,
  output logic        div_o,
  output logic        pulse_o,
  output logic        edge_o
);

  localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);

  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic                 en_q, en_d;
  logic                 mode_q, mode_d;
  logic [7:0]           filt_len_q, filt_len_d;
  logic [DIV_WIDTH-1:0] div_n_q, div_n_d;
  logic [31:0]          edgecnt_q, edgecnt_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic                 div_q, div_d;
  logic                 pulse_q, pulse_d;
  logic                 edge_q, edge_d;
  logic                 filt_prev_q;

  logic       hit, req, wr;
  logic       wr_ctrl, wr_div, wr_edgecnt;
  logic       filt_s, edge_det;
  reg_sel_e   rsel;
  logic [31:0] rdata;
  logic       unused_ok;

  assign hit  = (addr_i[31:4] == BASE_ADDR[31:4]);
  assign rsel = decode_reg(addr_i[3:0]);
  assign req  = cyc_i & stb_i & hit & ~(ack_q | err_q);
  assign wr   = ack_q & cyc_i & stb_i & hit & we_i & (sel_i == 4'hF);

  assign wr_ctrl    = wr & (rsel == REG_CTRL);
  assign wr_div     = wr & (rsel == REG_DIV);
  assign wr_edgecnt = wr & (rsel == REG_EDGECNT);

  glitch_filter #(.SYNC_STAGES(SYNC_STAGES)) u_filt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .sig_i      (signal_i),
    .filt_len_i (filt_len_q),
    .clr_run_i  (wr_ctrl),
    .filt_o     (filt_s)
  );

  assign edge_det = (filt_s & ~filt_prev_q) | (mode_q & ~filt_s & filt_prev_q);

  always_comb begin
    ack_d      = req & (rsel != REG_RSVD);
    err_d      = req & (rsel == REG_RSVD);
    en_d       = en_q;
    mode_d     = mode_q;
    filt_len_d = filt_len_q;
    div_n_d    = div_n_q;
    edgecnt_d  = edgecnt_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    pulse_d    = 1'b0;
    edge_d     = en_q & edge_det;

    if (wr_ctrl) begin
      en_d       = dat_i[CTRL_EN_BIT];
      mode_d     = dat_i[CTRL_MODE_BIT];
      filt_len_d = dat_i[CTRL_FILT_MSB:CTRL_FILT_LSB];
    end
    if (wr_div) div_n_d = dat_i[DIV_WIDTH-1:0];

    if (!en_q) begin
      cnt_d = '0;
      div_d = 1'b0;
    end else if (edge_o) begin
      if (div_n_q <= DIV_ONE || cnt_q == div_n_q - DIV_ONE) begin
        cnt_d   = '0;
        pulse_d = 1'b1;
        div_d   = ~div_q;
      end else begin
        cnt_d = cnt_q + DIV_ONE;
      end
    end
    // A new ratio or mode restarts the divided wave from a known phase.
    if (wr_ctrl || wr_div) begin
      cnt_d = '0;
      div_d = 1'b0;
    end

    if (wr_edgecnt)  edgecnt_d = 32'd0;
    else if (edge_o) edgecnt_d = edgecnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      en_q        <= 1'b0;
      mode_q      <= 1'b0;
      filt_len_q  <= 8'd0;
      div_n_q     <= DIV_ONE;
      edgecnt_q   <= 32'd0;
      cnt_q       <= '0;
      div_q       <= 1'b0;
      pulse_q     <= 1'b0;
      edge_q      <= 1'b0;
      filt_prev_q <= 1'b0;
    end else begin
      ack_q       <= ack_d;
      err_q       <= err_d;
      en_q        <= en_d;
      mode_q      <= mode_d;
      filt_len_q  <= filt_len_d;
      div_n_q     <= div_n_d;
      edgecnt_q   <= edgecnt_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      pulse_q     <= pulse_d;
      edge_q      <= edge_d;
      filt_prev_q <= filt_s;
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (ack_q) begin
      case (rsel)
        REG_CTRL:    rdata = {16'd0, filt_len_q, 6'd0, mode_q, en_q};
        REG_DIV:     rdata = 32'(div_n_q);
        REG_EDGECNT: rdata = edgecnt_q;
        default:     rdata = 32'd0;
      endcase
    end
  end

  assign dat_o   = rdata;
  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign rty_o   = 1'b0;
  assign edge_o  = edge_q & en_q;
  assign pulse_o = pulse_q & en_q;
  assign div_o   = div_q;

  assign unused_ok = ^dat_i;

endmodule
